// File: rtl/banco_pkg.sv
// Shared types and default widths for the multi-port register bank and its clear sequencer.
package banco_pkg;

  localparam int BIT_ADDR_DEF = 3;
  localparam int BIT_DATO_DEF = 8;
  localparam int NUM_RD_DEF   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/banco_clear_fsm.sv
// Sequential bank-clear controller: walks a counter across every register address,
// zeroing one register per cycle while busy is asserted.
module banco_clear_fsm
  import banco_pkg::*;
#(
  parameter int BIT_ADDR = BIT_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  output logic [BIT_ADDR-1:0] clr_addr,
  output logic                clr_we
);

  localparam logic [BIT_ADDR-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [BIT_ADDR-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end else begin
      // The counter wraps back to 0 on the last address, ready for the next sequence.
      cnt <= cnt + BIT_ADDR'(1);
      if (cnt == LAST_ADDR) state <= IDLE;
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/banco_registro_mp.sv
// Multi-read-port register bank with registered reads, optional hardwired-zero register
// and a sequential clear. Define BANCO_REGISTRO_BYPASS_EN for write-first forwarding.
module banco_registro_mp
  import banco_pkg::*;
#(
  parameter int BIT_ADDR = BIT_ADDR_DEF,
  parameter int BIT_DATO = BIT_DATO_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*BIT_ADDR-1:0]   rd_addr,
  output logic [NUM_RD*BIT_DATO-1:0]   rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         wr_en,
  input  logic [BIT_ADDR-1:0]          wr_addr,
  input  logic [BIT_DATO-1:0]          wr_data,
  input  logic                         clr_req,
  output logic                         busy
);

  localparam int NREG = 2 ** BIT_ADDR;

  logic [BIT_DATO-1:0] regs [NREG];
  logic [BIT_ADDR-1:0] clr_addr;
  logic                clr_we;
  logic                wr_accept;
  logic [BIT_DATO-1:0] rd_next [NUM_RD];

  banco_clear_fsm #(.BIT_ADDR(BIT_ADDR)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign wr_accept = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: the array is reset because cleared-to-zero contents after reset are architectural.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_accept) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [BIT_ADDR-1:0] addr;
    assign addr = rd_addr[g*BIT_ADDR +: BIT_ADDR];

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
      rd_next[g] = regs[addr];
      if ((ZERO_REG != 0) && (addr == '0)) rd_next[g] = '0;
`ifdef BANCO_REGISTRO_BYPASS_EN
      if (wr_accept && (wr_addr == addr)) rd_next[g] = wr_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) rd_data[i*BIT_DATO +: BIT_DATO] <= rd_next[i];
      end
    end
  end

endmodule

// File: tb/tb_banco_registro_mp.sv
// Self-checking bench for banco_registro_mp: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register bank.
module tb_banco_registro_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        clr_req;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: register contents, expected read outputs, remaining clear cycles.
  logic [7:0] m_mem [8];
  logic [7:0] m_rd  [2];
  logic       m_val [2];
  int         clr_left;

  banco_registro_mp #(.BIT_ADDR(3), .BIT_DATO(8), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      m_rd[p]  = 8'h00;
      m_val[p] = 1'b0;
    end
    clr_left = 0;
  endtask

  task automatic model_step();
    logic       wacc;
    logic [2:0] a;
    logic [7:0] v;
    wacc = wr_en && (clr_left == 0) && (wr_addr != 3'd0);
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*3 +: 3];
        v = (a == 3'd0) ? 8'h00 : m_mem[a];
`ifdef BANCO_REGISTRO_BYPASS_EN
        if (wacc && wr_addr == a) v = wr_data;
`endif
        m_rd[p]  = v;
        m_val[p] = 1'b1;
      end else begin
        m_val[p] = 1'b0;
      end
    end
    if (clr_left > 0) begin
      m_mem[8 - clr_left] = 8'h00;
      clr_left--;
    end else begin
      if (wacc) m_mem[wr_addr] = wr_data;
      if (clr_req) clr_left = 8;
    end
  endtask

  task automatic compare();
    check("rd_data0", {24'h0, rd_data[7:0]},  {24'h0, m_rd[0]});
    check("rd_data1", {24'h0, rd_data[15:8]}, {24'h0, m_rd[1]});
    check("rd_valid", {30'h0, rd_valid},      {30'h0, m_val[1], m_val[0]});
    check("busy",     {31'h0, busy},          {31'h0, clr_left > 0});
  endtask

  // One clock: model advances on the edge, DUT outputs are compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    rd_en = 2'b00; rd_addr = 6'h00;
    wr_en = 1'b0;  wr_addr = 3'd0; wr_data = 8'h00;
    clr_req = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    idle_inputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    idle_inputs();
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) write(3'(i), 8'((i << 4) | (i + 1)));
  endtask

  task automatic run_clear(output int len);
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    len = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      len++;
      if (len == 3) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77; end
      else          wr_en = 1'b0;
      clr_req = (len == 5);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    int len;
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    check("reset_rd_data", {16'h0, rd_data}, 32'h0);
    check("reset_rd_valid", {30'h0, rd_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    cycle();

    // Basic write then read on port 0.
    write(3'd3, 8'hA5);
    rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
    cycle();
    check("lit_read_a5", {24'h0, rd_data[7:0]}, 32'hA5);
    check("lit_valid0", {31'h0, rd_valid[0]}, 32'h1);
    idle_inputs();
    cycle();
    check("lit_valid_drop", {30'h0, rd_valid}, 32'h0);
    check("lit_hold_a5", {24'h0, rd_data[7:0]}, 32'hA5);

    // Hardwired zero register.
    write(3'd0, 8'hFF);
    rd_en = 2'b11; rd_addr = {3'd0, 3'd0};
    cycle();
    check("lit_zero_p0", {24'h0, rd_data[7:0]}, 32'h00);
    check("lit_zero_p1", {24'h0, rd_data[15:8]}, 32'h00);

    // Same-cycle write/read collision.
    write(3'd5, 8'h11);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
    rd_en = 2'b11; rd_addr = {3'd5, 3'd5};
    cycle();
`ifdef BANCO_REGISTRO_BYPASS_EN
    check("lit_collide_p0", {24'h0, rd_data[7:0]}, 32'h3C);
`else
    check("lit_collide_p0", {24'h0, rd_data[7:0]}, 32'h11);
`endif
    check("lit_collide_same", {24'h0, rd_data[15:8]}, {24'h0, rd_data[7:0]});
    idle_inputs();

    // Full clear: busy length, dropped write, all-zero contents afterwards.
    fill_all();
    run_clear(len);
    check("lit_busy_len", len, 32'd8);
    for (int a = 0; a < 8; a++) begin
      rd_en = 2'b11; rd_addr = {3'(a), 3'(a)};
      cycle();
      check("lit_cleared_p0", {24'h0, rd_data[7:0]}, 32'h0);
      check("lit_cleared_p1", {24'h0, rd_data[15:8]}, 32'h0);
    end
    idle_inputs();

    // Clear together with a write in the same idle cycle.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hC6; clr_req = 1'b1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 20 && busy; k++) begin
      rd_en = 2'b11; rd_addr = {3'd6, 3'd6};
      cycle();
    end
    rd_en = 2'b01; rd_addr = {3'd0, 3'd6};
    cycle();
    check("lit_clr_wr_cleared", {24'h0, rd_data[7:0]}, 32'h0);
    idle_inputs();

    // Asynchronous reset in the middle of a clear.
    fill_all();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    rd_en = 2'b11; rd_addr = {3'd7, 3'd6};
    for (int k = 0; k < 4; k++) cycle();
    check("lit_pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check("lit_async_rd_data", {16'h0, rd_data}, 32'h0);
    check("lit_async_busy", {31'h0, busy}, 32'h0);
    check("lit_async_valid", {30'h0, rd_valid}, 32'h0);
    model_reset();
    #2;
    rst = 1'b1;
    idle_inputs();
    cycle();
    write(3'd1, 8'h4B);
    write(3'd7, 8'h5A);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    len = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      len++;
      rd_en = 2'b11; rd_addr = {3'd7, 3'd1};
      cycle();
    end
    check("lit_restart_len", len, 32'd8);
    idle_inputs();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rd_en   = 2'($urandom);
      rd_addr = 6'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      clr_req = ($urandom_range(0, 24) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
